uart_tx_frame: RTL and testbench
================================

UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame (legal 5..9).
REQ-002 SHALL have port CLK  input  1  bit clock; one serial bit is emitted per rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload.
REQ-005 SHALL have port DATA_VALID  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  1 = parity bit appended.
REQ-007 SHALL have port PAR_TYP  input  2  parity mode: 00 even, 01 odd, 10 space, 11 mark.
REQ-008 SHALL have port STOP2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-009 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-010 SHALL have port BUSY  output  1  frame in progress.
REQ-011 SHALL have port PAR_BIT  output  1  registered parity bit of the latched frame.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL accept a request only in IDLE with DATA_VALID=1: latch P_DATA, PAR_EN, PAR_TYP and STOP2, compute PAR_BIT, and go to START on the same edge.
REQ-014 SHALL ignore DATA_VALID and all input changes in non-IDLE states; latched values govern the whole frame.
REQ-015 SHALL register BUSY=1 in every non-IDLE state and BUSY=0 in IDLE.
REQ-016 SHALL drive TX_OUT as a registered output: START = 0 for 1 cycle; DATA = latched bits LSB first, DATA_WIDTH cycles; PARITY = PAR_BIT for 1 cycle; STOP = 1 for 1 or 2 cycles; IDLE = 1.
REQ-017 SHALL skip the PARITY state (DATA to STOP directly) when the latched PAR_EN=0.
REQ-018 SHALL make the frame length 1+DATA_WIDTH+PAR_EN+(STOP2?2:1) cycles, with a minimum of 1 IDLE cycle between frames.
REQ-019 SHALL place the first start-bit cycle on TX_OUT in the cycle after the accepting edge (latency 1).
REQ-020 SHALL compute PAR_BIT as: even = XOR of data; odd = inverted XOR of data; space = 0; mark = 1.
REQ-021 SHALL hold PAR_BIT until the next accepted request, including when PAR_EN=0.
REQ-022 SHALL use a bit counter of width clog2(DATA_WIDTH) that wraps to 0 on leaving DATA, plus a 1-bit stop counter.

Reset
REQ-023 SHALL, while RST=0, force state IDLE, TX_OUT=1, BUSY=0, PAR_BIT=0, and clear the counters and latched data.
REQ-024 SHALL, on reset assertion mid-frame, abort the frame immediately with no stop bit; the first request after release starts a fresh frame.

Configuration
REQ-025 SHALL use macro UART_TX_MARK_SPACE_EN: when defined, all four PAR_TYP modes are supported.
REQ-026 SHALL, when UART_TX_MARK_SPACE_EN is undefined, ignore PAR_TYP[1] so that PAR_TYP[0] alone selects even (0) or odd (1).

Verification
REQ-027 SHALL cover: W=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=00, STOP2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 then idle; BUSY high 11 cycles; PAR_BIT=0.
REQ-028 SHALL cover: same data, PAR_TYP=01 -> parity slot=1; with PAR_EN=0, STOP2=1 -> 11 cycles, no parity slot, two stop bits high.
REQ-029 SHALL cover: P_DATA=0x00, PAR_TYP=11 with macro defined -> parity slot 1; same stimulus with macro undefined -> odd parity, slot 1; P_DATA=0x01, PAR_TYP=10 with macro defined -> slot 0, without macro -> even parity, slot 1.
REQ-030 SHALL cover: DATA_VALID held high continuously with P_DATA=0x3C -> back-to-back frames separated by exactly one IDLE cycle; P_DATA changed mid-frame -> the current frame is unaffected.
REQ-031 SHALL cover: RST pulsed low during data bit 4 -> TX_OUT=1, BUSY=0 asynchronously; the next request gives a complete correct frame.
REQ-032 SHALL cover: DATA_WIDTH=5, P_DATA=5'h1F, even parity, one stop bit -> 0,1,1,1,1,1,1,1 (8 cycles), PAR_BIT=1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, DATA_WIDTH payload bits LSB first, optional parity, one or two stop bits.
// Latency: the start bit appears on TX_OUT in the cycle after the accepting edge; one bit per CLK.
// Backpressure: requests are taken only in IDLE; DATA_VALID and all inputs are ignored while BUSY.
// Optional feature: define UART_TX_MARK_SPACE_EN to enable the space/mark parity modes.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  PAR_BIT
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] data_q, data_nxt;
   logic                  par_en_q, par_en_nxt;
   logic                  stop2_q, stop2_nxt;
   logic                  par_bit_nxt;
   logic                  tx_nxt;
   logic                  busy_nxt;
   logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
   logic                  stop_cnt, stop_cnt_nxt;
   logic [1:0]            par_sel;
   logic                  par_calc;

   // Parity of the incoming payload for the requested mode; without the
   // mark/space option only the odd/even selector bit is honoured.
   always_comb begin
`ifdef UART_TX_MARK_SPACE_EN
      par_sel = PAR_TYP;
`else
      par_sel = PAR_TYP & 2'b01;
`endif
      case (par_sel)
         2'b00:   par_calc = ^P_DATA;
         2'b01:   par_calc = ~^P_DATA;
         2'b10:   par_calc = 1'b0;
         default: par_calc = 1'b1;
      endcase
   end

   // Next-state and next-output logic; TX_OUT is computed one cycle ahead so it leaves a flop.
   always_comb begin
      state_nxt    = state;
      data_nxt     = data_q;
      par_en_nxt   = par_en_q;
      stop2_nxt    = stop2_q;
      par_bit_nxt  = PAR_BIT;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      tx_nxt       = 1'b1;
      case (state)
         IDLE: begin
            if (DATA_VALID) begin
               state_nxt   = START;
               data_nxt    = P_DATA;
               par_en_nxt  = PAR_EN;
               stop2_nxt   = STOP2;
               par_bit_nxt = par_calc;
               tx_nxt      = 1'b0;
            end
         end
         START: begin
            // Payload is shifted out of data_q so bit 0 is always the next to send.
            state_nxt   = DATA;
            tx_nxt      = data_q[0];
            data_nxt    = data_q >> 1;
            bit_cnt_nxt = '0;
         end
         DATA: begin
            if (bit_cnt == LAST_BIT) begin
               bit_cnt_nxt  = '0;
               stop_cnt_nxt = 1'b0;
               if (par_en_q) begin
                  state_nxt = PARITY;
                  tx_nxt    = PAR_BIT;
               end else begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
               tx_nxt      = data_q[0];
               data_nxt    = data_q >> 1;
            end
         end
         PARITY: begin
            state_nxt    = STOP;
            stop_cnt_nxt = 1'b0;
         end
         STOP: begin
            if (stop2_q && !stop_cnt) begin
               stop_cnt_nxt = 1'b1;
            end else begin
               stop_cnt_nxt = 1'b0;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State, latched frame parameters and registered outputs; reset aborts any frame at once.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         data_q   <= '0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         PAR_BIT  <= 1'b0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         TX_OUT   <= 1'b1;
         BUSY     <= 1'b0;
      end else begin
         state    <= state_nxt;
         data_q   <= data_nxt;
         par_en_q <= par_en_nxt;
         stop2_q  <= stop2_nxt;
         PAR_BIT  <= par_bit_nxt;
         bit_cnt  <= bit_cnt_nxt;
         stop_cnt <= stop_cnt_nxt;
         TX_OUT   <= tx_nxt;
         BUSY     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8-bit and a 5-bit instance checked cycle by cycle
// against a frame model built as a bit queue from payload, parity mode and stop count.
// Parity expectations follow UART_TX_MARK_SPACE_EN the same way the design build does.
module tb_uart_tx_frame;

   logic       CLK;
   logic       RST;
   logic [7:0] p_data8;
   logic       dv8, pe8, st8;
   logic [1:0] pt8;
   logic       tx8, busy8, pb8;
   logic [4:0] p_data5;
   logic       dv5, pe5, st5;
   logic [1:0] pt5;
   logic       tx5, busy5, pb5;

   int pass_cnt = 0;
   int total_cnt = 0;

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(p_data8), .DATA_VALID(dv8), .PAR_EN(pe8),
      .PAR_TYP(pt8), .STOP2(st8), .TX_OUT(tx8), .BUSY(busy8), .PAR_BIT(pb8)
   );

   uart_tx_frame #(.DATA_WIDTH(5)) dut5 (
      .CLK(CLK), .RST(RST), .P_DATA(p_data5), .DATA_VALID(dv5), .PAR_EN(pe5),
      .PAR_TYP(pt5), .STOP2(st5), .TX_OUT(tx5), .BUSY(busy5), .PAR_BIT(pb5)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference parity: count ones, then apply the mode rule.
   function automatic logic model_parity(input int w, input logic [8:0] data, input logic [1:0] pt);
      int   ones;
      logic odd_ones;
      ones = 0;
      for (int i = 0; i < w; i++) ones += int'(data[i]);
      odd_ones = (ones % 2) == 1;
`ifdef UART_TX_MARK_SPACE_EN
      case (pt)
         2'b00:   return odd_ones;
         2'b01:   return !odd_ones;
         2'b10:   return 1'b0;
         default: return 1'b1;
      endcase
`else
      return pt[0] ? !odd_ones : odd_ones;
`endif
   endfunction

   task automatic drive(input int w, input logic [8:0] data, input logic pe,
                        input logic [1:0] pt, input logic st2, input logic dv);
      if (w == 5) begin
         p_data5 = data[4:0]; pe5 = pe; pt5 = pt; st5 = st2; dv5 = dv;
      end else begin
         p_data8 = data[7:0]; pe8 = pe; pt8 = pt; st8 = st2; dv8 = dv;
      end
   endtask

   // Send one frame from an idle negedge, scrambling the inputs once it is accepted,
   // and check every line cycle, the following idle cycle and the held parity bit.
   task automatic run_frame(input int w, input logic [8:0] data, input logic pe,
                            input logic [1:0] pt, input logic st2, input string name);
      bit   exp_q[$];
      logic pexp;
      logic obs_tx, obs_busy, obs_pb;
      pexp = model_parity(w, data, pt);
      exp_q = {};
      exp_q.push_back(1'b0);
      for (int i = 0; i < w; i++) exp_q.push_back(data[i]);
      if (pe) exp_q.push_back(pexp);
      exp_q.push_back(1'b1);
      if (st2) exp_q.push_back(1'b1);
      drive(w, data, pe, pt, st2, 1'b1);
      @(negedge CLK);
      drive(w, 9'($urandom), ~pe, ~pt, ~st2, 1'b0);
      foreach (exp_q[i]) begin
         obs_tx   = (w == 5) ? tx5 : tx8;
         obs_busy = (w == 5) ? busy5 : busy8;
         total_cnt++;
         if (obs_tx !== exp_q[i])
            $display("FAIL %s tx bit %0d: got %b expected %b", name, i, obs_tx, exp_q[i]);
         else pass_cnt++;
         total_cnt++;
         if (obs_busy !== 1'b1)
            $display("FAIL %s busy bit %0d: got %b expected 1", name, i, obs_busy);
         else pass_cnt++;
         @(negedge CLK);
      end
      obs_tx   = (w == 5) ? tx5 : tx8;
      obs_busy = (w == 5) ? busy5 : busy8;
      obs_pb   = (w == 5) ? pb5 : pb8;
      total_cnt++;
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0)
         $display("FAIL %s idle after frame: got tx=%b busy=%b expected tx=1 busy=0", name, obs_tx, obs_busy);
      else pass_cnt++;
      total_cnt++;
      if (obs_pb !== pexp)
         $display("FAIL %s par_bit: got %b expected %b", name, obs_pb, pexp);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      drive(8, 9'h0, 1'b0, 2'b00, 1'b0, 1'b0);
      drive(5, 9'h0, 1'b0, 2'b00, 1'b0, 1'b0);
      @(negedge CLK);
      total_cnt++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || pb8 !== 1'b0)
         $display("FAIL reset w8: got tx=%b busy=%b par=%b expected 1 0 0", tx8, busy8, pb8);
      else pass_cnt++;
      total_cnt++;
      if (tx5 !== 1'b1 || busy5 !== 1'b0 || pb5 !== 1'b0)
         $display("FAIL reset w5: got tx=%b busy=%b par=%b expected 1 0 0", tx5, busy5, pb5);
      else pass_cnt++;
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      total_cnt++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0)
         $display("FAIL idle after release: got tx=%b busy=%b expected 1 0", tx8, busy8);
      else pass_cnt++;
   endtask

   task automatic test_directed();
      run_frame(8, 9'h0A5, 1'b1, 2'b00, 1'b0, "a5_even");
      run_frame(8, 9'h0A5, 1'b1, 2'b01, 1'b0, "a5_odd");
      run_frame(8, 9'h0A5, 1'b0, 2'b01, 1'b1, "a5_nopar_stop2");
      run_frame(8, 9'h000, 1'b1, 2'b11, 1'b0, "00_mark");
      run_frame(8, 9'h001, 1'b1, 2'b10, 1'b0, "01_space");
      run_frame(8, 9'h0FF, 1'b1, 2'b00, 1'b1, "ff_even_stop2");
   endtask

   task automatic test_width5();
      run_frame(5, 9'h01F, 1'b1, 2'b00, 1'b0, "w5_1f_even");
      run_frame(5, 9'h00A, 1'b0, 2'b01, 1'b1, "w5_0a_nopar");
   endtask

   // DATA_VALID held high: two frames, each followed by exactly one idle cycle.
   task automatic test_back_to_back();
      bit   exp_q[$];
      logic pexp;
      pexp = model_parity(8, 9'h03C, 2'b00);
      exp_q = {};
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back((8'h3C >> i) & 8'h01);
      exp_q.push_back(pexp);
      exp_q.push_back(1'b1);
      drive(8, 9'h03C, 1'b1, 2'b00, 1'b0, 1'b1);
      @(negedge CLK);
      for (int f = 0; f < 2; f++) begin
         foreach (exp_q[i]) begin
            total_cnt++;
            if (tx8 !== exp_q[i] || busy8 !== 1'b1)
               $display("FAIL b2b frame %0d bit %0d: got tx=%b busy=%b expected tx=%b busy=1",
                        f, i, tx8, busy8, exp_q[i]);
            else pass_cnt++;
            @(negedge CLK);
         end
         total_cnt++;
         if (tx8 !== 1'b1 || busy8 !== 1'b0)
            $display("FAIL b2b gap %0d: got tx=%b busy=%b expected tx=1 busy=0", f, tx8, busy8);
         else pass_cnt++;
         if (f == 1) dv8 = 1'b0;
         @(negedge CLK);
      end
      total_cnt++;
      if (busy8 !== 1'b0 || tx8 !== 1'b1)
         $display("FAIL b2b stop: got tx=%b busy=%b expected tx=1 busy=0", tx8, busy8);
      else pass_cnt++;
   endtask

   // Reset pulsed while data bit 4 is on the line: outputs fall back without a clock edge.
   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'h5A;
      drive(8, {1'b0, d}, 1'b1, 2'b01, 1'b1, 1'b1);
      @(negedge CLK);
      dv8 = 1'b0;
      repeat (5) @(negedge CLK);
      total_cnt++;
      if (tx8 !== d[4] || busy8 !== 1'b1)
         $display("FAIL mid-frame bit4: got tx=%b busy=%b expected tx=%b busy=1", tx8, busy8, d[4]);
      else pass_cnt++;
      #2 RST = 1'b0;
      #1;
      total_cnt++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || pb8 !== 1'b0)
         $display("FAIL async reset: got tx=%b busy=%b par=%b expected 1 0 0", tx8, busy8, pb8);
      else pass_cnt++;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      total_cnt++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0)
         $display("FAIL after reset pulse: got tx=%b busy=%b expected 1 0", tx8, busy8);
      else pass_cnt++;
      run_frame(8, 9'h0C3, 1'b1, 2'b00, 1'b0, "post_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++)
         run_frame(8, 9'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), "rand_w8");
      for (int n = 0; n < 8; n++)
         run_frame(5, 9'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), "rand_w5");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_width5();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
